// File: rtl/dat_mem_ctrl_if.sv
// dat_mem_ctrl_if: command/response channel between the core and dat_mem_ctrl.
//   cmd_valid/cmd_ready : command handshake; a command is taken when both are high at clk rise
//   cmd_op              : 00 LOAD, 01 STORE, 10 COPY, 11 FILL
//   cmd_addr            : LOAD/STORE address, COPY source, FILL start
//   cmd_dst             : COPY destination
//   cmd_len             : COPY/FILL byte count (0 = no memory access)
//   cmd_wdata           : STORE/FILL data
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata           : last LOAD result
//   busy                : controller is not idle
// Modports: master = core side, slave = controller side.
interface dat_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_dst;
    logic [7:0]        cmd_len;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/dat_mem_ctrl.sv
// dat_mem_ctrl: access sequencer driving an 8-bit x 256 data memory with combinational read.
// Executes LOAD/STORE of one byte and COPY/FILL of cmd_len bytes, one command at a time,
// and signals completion with a one-cycle rsp_valid pulse.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : command/response channel (dat_mem_ctrl_if.slave)
//   mem_addr     : memory address
//   mem_wdata    : memory write data
//   mem_wr_en    : memory write enable
//   mem_rd_en    : memory read enable
//   mem_rdata    : memory read data, combinational from mem_addr
// Build option: define DAT_MEM_CTRL_FILL_EN to implement FILL; otherwise op 11 completes
// immediately without touching memory.
module dat_mem_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dat_mem_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpStore = 2'b01;
    localparam logic [1:0] OpCopy  = 2'b10;

`ifdef DAT_MEM_CTRL_FILL_EN
    typedef enum logic [2:0] {
        StIdle, StLoad, StStore, StCpyRd, StCpyWr, StFill, StDone
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StLoad, StStore, StCpyRd, StCpyWr, StDone
    } state_e;
`endif

    state_e            state_q, state_d;
    // src_q doubles as LOAD/STORE address and FILL pointer.
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept;

    assign accept = (state_q == StIdle) && bus.cmd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (bus.cmd_op)
                        OpLoad:  state_d = StLoad;
                        OpStore: state_d = StStore;
                        OpCopy:  state_d = (bus.cmd_len == 8'd0) ? StDone : StCpyRd;
                        default: begin
`ifdef DAT_MEM_CTRL_FILL_EN
                            state_d = (bus.cmd_len == 8'd0) ? StDone : StFill;
`else
                            state_d = StDone;
`endif
                        end
                    endcase
                end
            end
            StLoad:  state_d = StDone;
            StStore: state_d = StDone;
            StCpyRd: state_d = StCpyWr;
            StCpyWr: state_d = (cnt_q == 8'd1) ? StDone : StCpyRd;
`ifdef DAT_MEM_CTRL_FILL_EN
            StFill:  state_d = (cnt_q == 8'd1) ? StDone : StFill;
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command capture and per-byte pointer/count stepping.
    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        byte_d  = byte_q;
        rdata_d = rdata_q;
        if (accept) begin
            src_d   = bus.cmd_addr;
            dst_d   = bus.cmd_dst;
            cnt_d   = bus.cmd_len;
            wdata_d = bus.cmd_wdata;
        end
        if (state_q == StLoad) begin
            rdata_d = mem_rdata;
        end
        if (state_q == StCpyRd) begin
            byte_d = mem_rdata;
        end
        if (state_q == StCpyWr) begin
            src_d = src_q + ADDR_W'(1);
            dst_d = dst_q + ADDR_W'(1);
            cnt_d = cnt_q - 8'd1;
        end
`ifdef DAT_MEM_CTRL_FILL_EN
        if (state_q == StFill) begin
            src_d = src_q + ADDR_W'(1);
            cnt_d = cnt_q - 8'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            byte_q  <= '0;
            rdata_q <= '0;
        end else begin
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            byte_q  <= byte_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode only registered state, so reset forces them low without a clock edge.
    always_comb begin
        bus.cmd_ready = (state_q == StIdle);
        bus.busy      = (state_q != StIdle);
        bus.rsp_valid = (state_q == StDone);
        bus.rsp_rdata = rdata_q;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wr_en     = 1'b0;
        mem_rd_en     = 1'b0;
        unique case (state_q)
            StLoad: begin
                mem_addr  = src_q;
                mem_rd_en = 1'b1;
            end
            StStore: begin
                mem_addr  = src_q;
                mem_wdata = wdata_q;
                mem_wr_en = 1'b1;
            end
            StCpyRd: begin
                mem_addr  = src_q;
                mem_rd_en = 1'b1;
            end
            StCpyWr: begin
                mem_addr  = dst_q;
                mem_wdata = byte_q;
                mem_wr_en = 1'b1;
            end
`ifdef DAT_MEM_CTRL_FILL_EN
            StFill: begin
                mem_addr  = src_q;
                mem_wdata = wdata_q;
                mem_wr_en = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dat_mem_ctrl.sv
// Testbench for dat_mem_ctrl: table-driven commands, randomized commands against a
// byte-array reference model, and hand-written held-valid and mid-COPY reset sequences.
module tb_dat_mem_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
`ifdef DAT_MEM_CTRL_FILL_EN
    localparam bit FillEn = 1'b1;
`else
    localparam bit FillEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dat_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_wr_en, mem_rd_en;

    dat_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata)
    );

    // Memory under the controller: combinational read, write at clock rise.
    logic [7:0] mem [256];
    logic       mem_init = 1'b1;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference model state.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_rdata;

    int checks = 0;
    int errors = 0;
    int nwr, nrd;
    int n_overlap = 0, n_idle_bad = 0, n_ready_bad = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr_en && mem_rd_en) n_overlap++;
            if (!bus.busy && (mem_wr_en || mem_rd_en || mem_addr != 8'd0 || mem_wdata != 8'd0))
                n_idle_bad++;
            if (bus.cmd_ready == bus.busy) n_ready_bad++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    // Behavioural model of one command: final memory image, LOAD result, cycle count, accesses.
    task automatic ref_apply(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] l, input logic [7:0] w,
                             output int lat, output int nw, output int nr);
        logic [7:0] s, t;
        lat = 1; nw = 0; nr = 0;
        s = a; t = d;
        case (op)
            2'b00: begin ref_rdata = ref_mem[a]; lat = 2; nr = 1; end
            2'b01: begin ref_mem[a] = w; lat = 2; nw = 1; end
            2'b10: begin
                for (int i = 0; i < int'(l); i++) begin
                    ref_mem[t] = ref_mem[s];
                    s++;
                    t++;
                end
                if (l != 8'd0) lat = 2 * int'(l) + 1;
                nw = int'(l); nr = int'(l);
            end
            default: begin
                if (FillEn) begin
                    for (int i = 0; i < int'(l); i++) begin
                        ref_mem[s] = w;
                        s++;
                    end
                    lat = int'(l) + 1;
                    nw = int'(l);
                end
            end
        endcase
    endtask

    // Called just after a falling edge with the controller idle.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] l, input logic [7:0] w);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_dst   = d;
        bus.cmd_len   = l;
        bus.cmd_wdata = w;
        chk("cmd_ready_at_issue", int'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_dst   = 8'($urandom);
        bus.cmd_len   = 8'($urandom);
        bus.cmd_wdata = 8'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1; nwr = 0; nrd = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (mem_wr_en) nwr++;
            if (mem_rd_en) nrd++;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] w, input int tbl_lat,
                           input string tag);
        int exp_lat, exp_wr, exp_rd, lat;
        ref_apply(op, a, d, l, w, exp_lat, exp_wr, exp_rd);
        issue(op, a, d, l, w);
        wait_rsp(lat);
        chk({tag, "_latency"}, lat, (tbl_lat >= 0) ? tbl_lat : exp_lat);
        chk({tag, "_wr_count"}, nwr, exp_wr);
        chk({tag, "_rd_count"}, nrd, exp_rd);
        chk({tag, "_rsp_rdata"}, int'(bus.rsp_rdata), int'(ref_rdata));
        @(negedge clk);
        chk({tag, "_rsp_one_cycle"}, int'(bus.rsp_valid), 0);
        chk({tag, "_ready_after"}, int'(bus.cmd_ready), 1);
        chk({tag, "_mem_image_diffs"}, mem_diff(), 0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] dst;
        logic [7:0] len;
        logic [7:0] wdata;
        int         lat;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int lat, nw_cp;
        int dummy_lat, dummy_w, dummy_r;

        vecs[0]  = '{2'b01, 8'h10, 8'h00, 8'd0, 8'hA5, 2};
        vecs[1]  = '{2'b00, 8'h10, 8'h00, 8'd0, 8'h00, 2};
        vecs[2]  = '{2'b11, 8'hFE, 8'h00, 8'd4, 8'h3C, FillEn ? 5 : 1};
        vecs[3]  = '{2'b00, 8'h01, 8'h00, 8'd0, 8'h00, 2};
        vecs[4]  = '{2'b01, 8'h20, 8'h00, 8'd0, 8'h11, 2};
        vecs[5]  = '{2'b01, 8'h21, 8'h00, 8'd0, 8'h22, 2};
        vecs[6]  = '{2'b01, 8'h22, 8'h00, 8'd0, 8'h33, 2};
        vecs[7]  = '{2'b10, 8'h20, 8'h40, 8'd3, 8'h00, 7};
        vecs[8]  = '{2'b00, 8'h42, 8'h00, 8'd0, 8'h00, 2};
        vecs[9]  = '{2'b10, 8'h50, 8'h60, 8'd0, 8'h00, 1};
        vecs[10] = '{2'b11, 8'h70, 8'h00, 8'd0, 8'h99, 1};
        vecs[11] = '{2'b10, 8'h20, 8'h21, 8'd3, 8'h00, 7};
        vecs[12] = '{2'b00, 8'h23, 8'h00, 8'd0, 8'h00, 2};
        vecs[13] = '{2'b10, 8'hFE, 8'h01, 8'd3, 8'h00, 7};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        ref_rdata     = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 8'h00;
        bus.cmd_dst   = 8'h00;
        bus.cmd_len   = 8'h00;
        bus.cmd_wdata = 8'h00;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
        chk("reset_rsp_rdata", int'(bus.rsp_rdata), 0);
        chk("reset_mem_wr_en", int'(mem_wr_en), 0);
        chk("reset_mem_rd_en", int'(mem_rd_en), 0);
        chk("reset_mem_addr", int'(mem_addr), 0);
        chk("reset_mem_wdata", int'(mem_wdata), 0);
        rst_n = 1'b1;
        #1;
        chk("reset_cmd_ready", int'(bus.cmd_ready), 1);
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].dst, vecs[i].len, vecs[i].wdata,
                    vecs[i].lat, $sformatf("vec%0d", i));
        end

        // cmd_valid held with changing fields during a 3-byte COPY.
        ref_apply(2'b10, 8'h20, 8'h80, 8'd3, 8'h00, dummy_lat, dummy_w, dummy_r);
        issue(2'b10, 8'h20, 8'h80, 8'd3, 8'h00);
        bus.cmd_valid = 1'b1;
        lat = -1; nw_cp = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (mem_wr_en) nw_cp++;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
            bus.cmd_op    = 2'($urandom);
            bus.cmd_addr  = 8'($urandom);
            bus.cmd_dst   = 8'($urandom);
            bus.cmd_len   = 8'($urandom);
            bus.cmd_wdata = 8'($urandom);
        end
        chk("held_copy_latency", lat, 7);
        chk("held_copy_wr_count", nw_cp, 3);
        bus.cmd_op    = 2'b01;
        bus.cmd_addr  = 8'h90;
        bus.cmd_wdata = 8'h77;
        ref_apply(2'b01, 8'h90, 8'h00, 8'd0, 8'h77, dummy_lat, dummy_w, dummy_r);
        @(negedge clk);
        chk("held_second_ready", int'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_rsp(lat);
        chk("held_second_latency", lat, 2);
        @(negedge clk);
        chk("held_mem_image_diffs", mem_diff(), 0);

        // Reset during the second byte of a 4-byte COPY.
        run_cmd(2'b01, 8'hA0, 8'h00, 8'd0, 8'hC1, -1, "pre_a0");
        run_cmd(2'b01, 8'hA1, 8'h00, 8'd0, 8'hC2, -1, "pre_a1");
        run_cmd(2'b01, 8'hB1, 8'h00, 8'd0, 8'hEE, -1, "pre_b1");
        issue(2'b10, 8'hA0, 8'hB0, 8'd4, 8'h00);
        repeat (4) @(negedge clk);
        chk("rst_pre_wr_en", int'(mem_wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_wr_en", int'(mem_wr_en), 0);
        chk("rst_mem_rd_en", int'(mem_rd_en), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_rdata", int'(bus.rsp_rdata), 0);
        ref_mem[8'hB0] = 8'hC1;
        ref_rdata      = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", int'(bus.cmd_ready), 1);
        @(negedge clk);
        chk("rst_no_rsp", int'(bus.rsp_valid), 0);
        chk("rst_mem_image_diffs", mem_diff(), 0);
        run_cmd(2'b00, 8'hB0, 8'h00, 8'd0, 8'h00, 2, "post_rst_load");

        // Randomized commands against the model.
        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                    8'($urandom_range(0, 12)), 8'($urandom), -1, $sformatf("rand%0d", i));
        end

        chk("rd_wr_overlap_cycles", n_overlap, 0);
        chk("idle_nonzero_mem_outputs", n_idle_bad, 0);
        chk("ready_busy_conflict", n_ready_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dat_mem_ctrl.md
# dat_mem_ctrl

Command-driven access sequencer that acts as the requesting side of the 8-bit × 256 data memory. It drives address, write data, write enable and read enable into the memory and samples its combinational read data. It accepts single-byte load/store commands and multi-byte copy/fill commands from the core over a valid/ready handshake, and reports completion with a one-cycle response pulse.

## Interface
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 8, memory data width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready at a rising edge
- cmd_op  input  2  00 LOAD, 01 STORE, 10 COPY, 11 FILL
- cmd_addr  input  ADDR_W  LOAD/STORE address; COPY source; FILL start
- cmd_dst  input  ADDR_W  COPY destination; ignored otherwise
- cmd_len  input  8  COPY/FILL byte count; 0 = no memory access
- cmd_wdata  input  DATA_W  STORE/FILL data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  DATA_W  LOAD result; held until the next LOAD completes
- busy  output  1  high in every state except IDLE
- mem_addr  output  ADDR_W  to memory address
- mem_wdata  output  DATA_W  to memory write data
- mem_wr_en  output  1  to memory write enable
- mem_rd_en  output  1  to memory read enable
- mem_rdata  input  DATA_W  from memory, combinational from mem_addr

## Operation
- States: IDLE, LOAD, STORE, CPY_RD, CPY_WR, FILL, DONE.
- Command fields are registered at acceptance. Later changes on cmd_* have no effect.
- IDLE: cmd_ready=1. On accept, go to LOAD, STORE, CPY_RD or FILL per op. If cmd_len==0 for COPY/FILL, go directly to DONE.
- LOAD: mem_addr=addr, mem_rd_en=1; capture mem_rdata into rsp_rdata at the clock edge; go to DONE.
- STORE: mem_addr=addr, mem_wdata=wdata, mem_wr_en=1 for one cycle; go to DONE.
- CPY_RD: mem_addr=src, mem_rd_en=1; latch mem_rdata into internal byte register; go to CPY_WR.
- CPY_WR: mem_addr=dst, mem_wdata=latched byte, mem_wr_en=1. Then src+1, dst+1, remaining count−1. Go to DONE if the count reaches 0, otherwise back to CPY_RD.
- FILL: mem_addr=ptr, mem_wdata=wdata, mem_wr_en=1 every cycle. Then ptr+1, count−1. Go to DONE when the count reaches 0.
- DONE: rsp_valid=1 for exactly one cycle; cmd_ready=0; go to IDLE.
- Address arithmetic is ADDR_W-bit with silent wrap: 0xFF+1 = 0x00.
- COPY processes bytes in ascending order. Overlapping regions with dst > src produce forward-propagation smear; this is the required behaviour and is not corrected.
- mem_wr_en and mem_rd_en are never high in the same cycle. Outside active states, all mem_* outputs are 0.

## Timing
- Reset (asynchronous, immediate): state IDLE; cmd_ready=1 once rst_n deasserts; rsp_valid=0; rsp_rdata=0; busy=0; mem_addr=0; mem_wdata=0; mem_wr_en=0; mem_rd_en=0.
- Reset mid-operation: mem_wr_en drops without waiting for a clock edge. Bytes already written stay written. No response pulse is issued.
- Accept at edge T. The response pulse occurs during the cycle after edge:
  - LOAD, STORE: T+2.
  - COPY of N bytes: T+2N+1.
  - FILL of N bytes: T+N+1.
  - COPY/FILL with len 0: T+1.
- The next command can be accepted at the edge ending the DONE cycle + 1, i.e. the first IDLE cycle.
- cmd_valid held while busy: not accepted. It is accepted on the first IDLE edge.
- mem_* outputs are registered state-decoded. They must be glitch-free from the state register.

## Configuration
- DAT_MEM_CTRL_FILL_EN defined: FILL op is implemented as above.
- DAT_MEM_CTRL_FILL_EN undefined: FILL state is absent. op 11 is accepted and goes directly to DONE, with no memory write and rsp_valid at T+1.

## Test plan
- Reset then STORE addr 0x10 data 0xA5 -> one cycle mem_wr_en=1, mem_addr=0x10, mem_wdata=0xA5. Then LOAD 0x10 -> rsp_valid at T+2 with rsp_rdata=0xA5.
- FILL addr 0xFE len 4 data 0x3C (macro defined) -> writes to 0xFE, 0xFF, 0x00, 0x01; rsp_valid at T+5. With the macro undefined, no writes and rsp_valid at T+1.
- COPY src 0x20 dst 0x40 len 3 with memory 0x20..0x22 = 11,22,33 -> 0x40..0x42 = 11,22,33; rsp_valid at T+7; rd_en and wr_en alternate and never overlap.
- COPY len 0 and FILL len 0 -> no mem_wr_en or mem_rd_en; rsp_valid at T+1.
- cmd_valid held high with changing fields during a 3-byte COPY -> cmd_ready=0 and no field effects. A second command is accepted on the first IDLE edge.
- rst_n low during the 2nd byte of COPY len 4 -> mem_wr_en=0 immediately, all outputs at reset values, no rsp_valid, first byte retained in memory.
